// File: rtl/glb_stream_pkg.sv
// Shared types and width helpers for the GLB stream source.
// Channel FSM encodings stay plain constants so older benches can match on raw values.
package glb_stream_pkg;

  typedef logic [2:0] chan_state_t;

  localparam chan_state_t ST_IDLE   = 3'd0;
  localparam chan_state_t ST_ARMED  = 3'd1;
  localparam chan_state_t ST_DELAY  = 3'd2;
  localparam chan_state_t ST_STREAM = 3'd3;
  localparam chan_state_t ST_EOS    = 3'd4;
  localparam chan_state_t ST_DONE   = 3'd5;

  localparam int unsigned DEF_DATA_W = 16;
  // Position of the token flag in a default-width stream word.
  localparam int unsigned TOKEN_BIT  = DEF_DATA_W;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the count n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int unsigned stream_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/glb_stream_chan.sv
// One stream channel: word buffer, sequencing FSM, counters and the registered output word.
// The buffer is read combinationally so each next word is registered without a bubble.
module glb_stream_chan
  import glb_stream_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DEPTH       = 2048,
  parameter int unsigned       START_DELAY = 3,
  parameter logic [DATA_W-1:0] EOS_VAL     = '0,
  localparam int unsigned      AW          = idx_w(DEPTH),
  localparam int unsigned      CW          = cnt_w(DEPTH),
  localparam int unsigned      DW          = idx_w(START_DELAY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              en,
  input  logic [CW-1:0]     tx_size,
  input  logic [7:0]        rep,
  input  logic              eos_en,
  input  logic              ready,
  output logic [DATA_W:0]   data,
  output logic              valid,
  output logic              done
);

  localparam logic [DW-1:0] LAST_CNT = DW'(START_DELAY - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  chan_state_t     state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [7:0]      pass_q, pass_d;
  logic [DATA_W:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic [CW-1:0]   tx_eff;
  logic [CW-1:0]   last_idx;
  logic [7:0]      last_pass;
  logic [AW-1:0]   ptr_inc;
  logic            launch;
  logic            finish;

  // Buffer contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign tx_eff    = (tx_size > CW'(DEPTH)) ? CW'(DEPTH) : tx_size;
  assign last_idx  = tx_eff - 1'b1;
  assign last_pass = (rep == 8'd0) ? 8'd0 : rep - 8'd1;
  assign ptr_inc   = ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    pass_d  = pass_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    launch  = 1'b0;
    finish  = 1'b0;

    if (flush && (state_q != ST_IDLE)) begin
      // Abort or restart; a channel disabled meanwhile falls back to idle.
      state_d = en ? ST_ARMED : ST_IDLE;
      cnt_d   = '0;
      ptr_d   = '0;
      pass_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush && en) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          cnt_d = '0;
          if (START_DELAY == 0) begin
            launch = 1'b1;
          end else begin
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (cnt_q == LAST_CNT) begin
            launch = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STREAM: begin
          if (ready) begin
            if (CW'(ptr_q) != last_idx) begin
              ptr_d  = ptr_inc;
              data_d = {1'b0, mem[ptr_inc]};
            end else if (pass_q != last_pass) begin
              ptr_d  = '0;
              pass_d = pass_q + 8'd1;
              data_d = {1'b0, mem[0]};
            end else begin
              finish = 1'b1;
            end
          end
        end
        ST_EOS: begin
          if (ready) begin
            state_d = ST_DONE;
            data_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (launch) begin
        ptr_d  = '0;
        pass_d = '0;
        if (tx_eff != '0) begin
          state_d = ST_STREAM;
          data_d  = {1'b0, mem[0]};
          valid_d = 1'b1;
        end else begin
          finish = 1'b1;
        end
      end

      if (finish) begin
        if (eos_en) begin
          state_d = ST_EOS;
          data_d  = {1'b1, EOS_VAL};
          valid_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          data_d  = '0;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      pass_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      pass_q  <= pass_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: rtl/glb_stream_src.sv
// Multi-channel GLB stream source: per-channel replay buffers behind a shared load port.
// Decodes the load port per channel and reduces per-channel completion into all_done.
module glb_stream_src
  import glb_stream_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       DEPTH       = 2048,
  parameter int unsigned       START_DELAY = 3,
  parameter logic [DATA_W-1:0] EOS_VAL     = '0,
  localparam int unsigned      AW          = idx_w(DEPTH),
  localparam int unsigned      CW          = cnt_w(DEPTH),
  localparam int unsigned      CHW         = idx_w(NUM_CH),
  localparam int unsigned      SW          = stream_w(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ld_en,
  input  logic [CHW-1:0]       ld_ch,
  input  logic [AW-1:0]        ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [NUM_CH-1:0]    cfg_en,
  input  logic [NUM_CH*CW-1:0] cfg_tx_size,
  input  logic [NUM_CH*8-1:0]  cfg_repeat,
  input  logic [NUM_CH-1:0]    cfg_eos,
  output logic [NUM_CH*SW-1:0] data,
  output logic [NUM_CH-1:0]    valid,
  input  logic [NUM_CH-1:0]    ready,
  output logic [NUM_CH-1:0]    done,
  output logic                 all_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;

    // Channel numbers past NUM_CH never match, so such loads are dropped.
    assign we = ld_en && (ld_ch == CHW'(i));

    glb_stream_chan #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .START_DELAY (START_DELAY),
      .EOS_VAL     (EOS_VAL)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .we      (we),
      .waddr   (ld_addr),
      .wdata   (ld_data),
      .en      (cfg_en[i]),
      .tx_size (cfg_tx_size[i*CW +: CW]),
      .rep     (cfg_repeat[i*8 +: 8]),
      .eos_en  (cfg_eos[i]),
      .ready   (ready[i]),
      .data    (data[i*SW +: SW]),
      .valid   (valid[i]),
      .done    (done[i])
    );
  end

  assign all_done = &(done | ~cfg_en);

endmodule
